fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the instruction buffer entry count (2..4).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 The block SHALL have port imem_req  output  1  fetch issued this cycle.
REQ-006 The block SHALL have port imem_addr  output  32  byte address of fetch; bits [1:0] always 0.
REQ-007 The block SHALL have port imem_rdata  input  32  instruction word, valid exactly 1 cycle after imem_req.
REQ-008 The block SHALL have port redirect_valid  input  1  branch/jump/trap redirect strobe.
REQ-009 The block SHALL have port redirect_pc  input  32  redirect target.
REQ-010 The block SHALL have port out_valid  output  1  buffer head holds an instruction.
REQ-011 The block SHALL have port out_ready  input  1  decode accepts head.
REQ-012 The block SHALL have port out_ir  output  32  head instruction.
REQ-013 The block SHALL have port out_pc  output  32  address of head instruction.

Function
REQ-014 The block SHALL implement states BOOT (first cycle after reset release, no fetch) and RUN; BOOT->RUN unconditionally; RUN persists until reset.
REQ-015 In RUN, imem_req SHALL be 1 iff (entries held + fetches in flight) < DEPTH and redirect_valid is 0 or the fetch targets redirect_pc (REQ-018).
REQ-016 Each issued fetch SHALL advance fetch_pc by 4; fetch_pc 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-017 A response SHALL be written at the buffer tail with its fetch address one cycle after issue; out_valid SHALL rise the cycle after that write (fetch-to-out latency 2 cycles).
REQ-018 redirect_valid in cycle t SHALL: clear the buffer at edge t; discard any response arriving at t+1 from a pre-redirect fetch (epoch bit); set imem_addr = {redirect_pc[31:2],2'b00} with imem_req=1 in cycle t+1; out_valid=0 in cycle t+1.
REQ-019 redirect SHALL take priority over a simultaneous out_ready handshake, response write and fetch issue; a handshake in cycle t still counts as consumed.
REQ-020 A simultaneous pop and push on a full buffer SHALL be accepted without loss or stall.
REQ-021 out_ir and out_pc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Back-to-back redirects SHALL each take effect; only the last target is fetched.
REQ-023 With out_ready held 1 and no redirects, steady state SHALL deliver one instruction per cycle.

Reset
REQ-024 While rst_n=0: state=BOOT, fetch_pc=RESET_PC, buffer empty, in-flight cleared, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_ir=0, out_pc=0.
REQ-025 Reset asserted mid-operation SHALL abandon in-flight fetches; first fetch after release SHALL be RESET_PC in the cycle after BOOT.

Structure
REQ-026 RESET_PC default, the BOOT/RUN state encoding and the NOP word 32'h0000_0013 SHALL live in a shared core package.
REQ-027 The buffer SHALL be one sub-module, fetch_buf (DEPTH-entry {pc,ir} FIFO with flush, full, empty).

Verification
REQ-028 Reset release, out_ready=1 -> imem_addr 0x0,0x4,0x8 on cycles 1,2,3 after BOOT; out_pc 0x0 valid 2 cycles after first fetch.
REQ-029 out_ready=0 for 10 cycles -> exactly DEPTH fetches issued, then imem_req=0; out_pc held 0x0.
REQ-030 redirect to 0x0000_0100 while a fetch is in flight -> next imem_addr 0x100, stale response dropped, next out_pc 0x100.
REQ-031 redirect_pc 0x0000_0203 -> imem_addr 0x0000_0200.
REQ-032 RESET_PC=0xFFFF_FFF8, out_ready=1 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-033 rst_n dropped with full buffer -> out_valid=0 same cycle; after release first fetch RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions for the instruction fetch front end:
// reset vector default, fetch sequencer state encoding and the canonical NOP.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry {pc, ir} FIFO between instruction memory and decode.
// Flush empties the buffer and wins over a same-cycle push or pop.
module fetch_buf #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_pc,
  input  logic [31:0]                push_ir,
  input  logic                       pop,
  output logic [31:0]                head_pc,
  output logic [31:0]                head_ir,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   ir_mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign head_pc = pc_mem[rd_ptr_q];
  assign head_ir = ir_mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        ir_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        pc_mem[wr_ptr_q] <= push_pc;
        ir_mem[wr_ptr_q] <= push_ir;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues sequential fetches with credit-based
// flow control into fetch_buf and handles redirects with an epoch tag.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [31:0]   fetch_pc_q;
  logic          infl_q;
  logic [31:0]   infl_pc_q;
  logic          infl_epoch_q;
  logic          epoch_q;
  logic          pop;
  logic          push;
  logic          buf_full;
  logic          buf_empty;
  logic [CW-1:0] buf_count;
  logic [CW:0]   occ;

  assign pop       = out_valid && out_ready;
  // Responses from fetches issued before the latest redirect carry a stale epoch.
  assign push      = infl_q && (infl_epoch_q == epoch_q) && !redirect_valid;
  assign out_valid = !buf_empty;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    // Occupancy once this cycle's response lands and the head (if taken) leaves.
    occ      = (CW+1)'(buf_count) + (CW+1)'(infl_q) - (CW+1)'(pop);
    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end else begin
      imem_req = !redirect_valid && (occ < (CW+1)'(DEPTH)) && (!buf_full || pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      fetch_pc_q   <= RESET_PC & ~32'h3;
      infl_q       <= 1'b0;
      infl_pc_q    <= '0;
      infl_epoch_q <= 1'b0;
      epoch_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      infl_q       <= imem_req;
      infl_pc_q    <= fetch_pc_q;
      infl_epoch_q <= epoch_q;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc & ~32'h3;
        epoch_q    <= ~epoch_q;
      end else if (imem_req) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
    end
  end

  fetch_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .push    (push),
    .push_pc (infl_pc_q),
    .push_ir (imem_rdata),
    .pop     (pop),
    .head_pc (out_pc),
    .head_ir (out_ir),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic checked
// against a queue-based model of the fetch/buffer rules.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_ir;
  logic [31:0] w_out_pc;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_ir(w_out_ir), .out_pc(w_out_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        m_q[$];
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_pc;

  int          n_vec;
  int          n_err;
  logic        prev_req;
  logic [31:0] prev_addr;
  logic        obs_req, obs_valid, obs_wreq;
  logic [31:0] obs_addr, obs_pc, obs_waddr;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_boot    = 1'b1;
    m_pc      = 32'h0000_0000;
    m_infl    = 1'b0;
    m_infl_pc = '0;
    prev_req  = 1'b0;
    prev_addr = '0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0000);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_ir", out_ir, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_w_addr", w_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    bit          exp_v;
    bit          pop;
    bit          exp_req;
    int          occ;
    logic [31:0] pc_now;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    imem_rdata     = prev_req ? imem_word(prev_addr) : $urandom();
    #1;
    exp_v   = (m_q.size() > 0);
    pop     = exp_v && rdy;
    occ     = m_q.size() + int'(m_infl) - int'(pop);
    exp_req = !m_boot && !rv && (occ < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    if (exp_v) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_ir", out_ir, m_q[0].ir);
    end
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = out_valid;
    obs_pc    = out_pc;
    obs_wreq  = w_req;
    obs_waddr = w_addr;
    pc_now    = m_pc;
    if (rv) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back('{m_infl_pc, imem_word(m_infl_pc)});
      if (exp_req) m_pc = m_pc + 32'd4;
    end
    m_infl    = exp_req;
    m_infl_pc = pc_now;
    m_boot    = 1'b0;
    prev_req  = imem_req;
    prev_addr = imem_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  nreq;
    int  nval;
    bit  got;
    n_vec            = 0;
    n_err            = 0;
    imem_rdata       = '0;
    w_rdata          = '0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_out_ready      = 1'b1;
    do_reset();

    // sequential start-up and the wrap-around instance
    step(1'b0, 32'h0, 1'b1);
    chk("boot_no_req", {31'b0, obs_req}, 32'd0);
    chk("w_boot_no_req", {31'b0, obs_wreq}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("first_fetch", obs_addr, 32'h0);
    chk("w_fetch0", obs_waddr, 32'hFFFF_FFF8);
    step(1'b0, 32'h0, 1'b1);
    chk("second_fetch", obs_addr, 32'h4);
    chk("w_fetch1", obs_waddr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1);
    chk("third_fetch", obs_addr, 32'h8);
    chk("first_out_valid", {31'b0, obs_valid}, 32'd1);
    chk("first_out_pc", obs_pc, 32'h0);
    chk("w_fetch2", obs_waddr, 32'h0);
    chk("w_fetch2_req", {31'b0, obs_wreq}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // decode stalled: only DEPTH fetches go out
    do_reset();
    nreq = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 32'h0, 1'b0);
      nreq += int'(obs_req);
    end
    chk("stall_fetch_count", nreq, DEPTH);
    chk("stall_req_low", {31'b0, obs_req}, 32'd0);
    chk("stall_head_pc", obs_pc, 32'h0);

    // redirect with a fetch in flight
    step(1'b0, 32'h0, 1'b1);
    chk("inflight_req", {31'b0, obs_req}, 32'd1);
    step(1'b1, 32'h0000_0100, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("redir_addr", obs_addr, 32'h100);
    chk("redir_req", {31'b0, obs_req}, 32'd1);
    chk("redir_valid_low", {31'b0, obs_valid}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (obs_valid) got = 1'b1;
    end
    chk("redir_wait", {31'b0, got}, 32'd1);
    chk("redir_out_pc", obs_pc, 32'h100);

    // misaligned target
    step(1'b1, 32'h0000_0203, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("align_addr", obs_addr, 32'h200);

    // back-to-back redirects
    step(1'b1, 32'h0000_0300, 1'b1);
    step(1'b1, 32'h0000_0400, 1'b1);
    chk("b2b_no_req", {31'b0, obs_req}, 32'd0);
    step(1'b0, 32'h0, 1'b0);
    chk("b2b_addr", obs_addr, 32'h400);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (obs_valid) got = 1'b1;
    end
    chk("b2b_wait", {31'b0, got}, 32'd1);
    chk("b2b_out_pc", obs_pc, 32'h400);

    // steady-state throughput
    nval = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (i >= 10) nval += int'(obs_valid);
    end
    chk("throughput", nval, 10);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) == 0), $urandom(), ($urandom_range(3) != 0));
    end

    // reset with a full buffer
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    chk("full_before_rst", {31'b0, obs_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_async_pc", out_pc, 32'd0);
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("post_rst_fetch", obs_addr, 32'h0);
    chk("post_rst_req", {31'b0, obs_req}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
